sniffer_cmd_ctrl: RTL and testbench
===================================

SNIFFER_CMD_CTRL -- requirements
Module: sniffer_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: max cycles to wait for reg_done before aborting an access (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port rx_data  input  8  head byte of UART Rx FIFO, first-word-fall-through, valid while rx_empty=0.
REQ-005 SHALL have port rx_empty  input  1  UART Rx FIFO empty.
REQ-006 SHALL have port rx_nxt  output  1  one-cycle pop strobe to UART Rx FIFO.
REQ-007 SHALL have port tx_data  output  8  response byte to UART Tx.
REQ-008 SHALL have port tx_send  output  1  one-cycle write strobe to UART Tx.
REQ-009 SHALL have port tx_full  input  1  UART Tx buffer full.
REQ-010 SHALL have port reg_addr  output  6  ULPI register address.
REQ-011 SHALL have port reg_wdata  output  8  ULPI register write value.
REQ-012 SHALL have port reg_we  output  1  1=write access, 0=read access; valid while reg_req=1.
REQ-013 SHALL have port reg_req  output  1  ULPI register access request, level.
REQ-014 SHALL have port reg_rdata  input  8  ULPI register read value, valid in the reg_done cycle.
REQ-015 SHALL have port reg_done  input  1  one-cycle access-complete pulse from ULPI controller.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port err  output  1  sticky error flag: timeout or invalid command since reset.

Function
REQ-018 Command byte SHALL be decoded as: bit7=W (1 write, 0 read), bit6 must be 0, bits5:0 = address; a write command SHALL be followed by one data byte.
REQ-019 FSM states SHALL be IDLE, GET_DATA, ACCESS, RESPOND.
REQ-020 IDLE: when rx_empty=0, SHALL assert rx_nxt for one cycle and latch rx_data; bit6=1 -> RESPOND with 0x15, set err; W=1 -> GET_DATA; W=0 -> ACCESS.
REQ-021 rx_nxt SHALL never be asserted in two consecutive cycles; GET_DATA SHALL not sample rx_empty in the cycle immediately after a pop.
REQ-022 GET_DATA: when rx_empty=0 (and not the post-pop cycle), SHALL pulse rx_nxt, latch rx_data into reg_wdata, go to ACCESS; waits indefinitely otherwise.
REQ-023 ACCESS: reg_req SHALL be 1 from the first ACCESS cycle until and including the reg_done cycle; reg_addr, reg_we, reg_wdata SHALL be stable throughout.
REQ-024 On reg_done in ACCESS: read -> response byte = reg_rdata; write -> response byte = 0x06; go to RESPOND; reg_req deasserted next cycle.
REQ-025 Timeout counter (width clog2(TIMEOUT+1)) SHALL clear on ACCESS entry, increment each ACCESS cycle; on reaching TIMEOUT without reg_done -> drop reg_req, response 0x15, set err, go to RESPOND.
REQ-026 reg_done and timeout in the same cycle: reg_done SHALL win.
REQ-027 reg_done outside ACCESS SHALL be ignored.
REQ-028 RESPOND: tx_data SHALL hold the response byte; when tx_full=0, tx_send SHALL pulse one cycle and FSM SHALL return to IDLE; while tx_full=1, wait with tx_send=0.
REQ-029 Commands SHALL be processed strictly in order, one at a time; no rx pop during ACCESS or RESPOND.
REQ-030 Latency: read cmd popped in cycle N, reg_req first high in N+1; reg_done in cycle M gives tx_send in M+1 when tx_full=0.

Reset
REQ-031 rst=1 SHALL asynchronously force state IDLE, rx_nxt=0, tx_send=0, reg_req=0, reg_we=0, busy=0, err=0, reg_addr=0, reg_wdata=0, tx_data=0, timeout counter=0.
REQ-032 Reset mid-ACCESS SHALL drop reg_req immediately; no response byte is sent for the aborted command.
REQ-033 err SHALL only clear on reset.

Verification
REQ-034 Read: rx byte 0x0A, reg_done with reg_rdata=0x24 after 5 cycles -> reg_addr=0x0A, reg_we=0, one tx_send with tx_data=0x24, err=0.
REQ-035 Write: rx bytes 0x84, 0x55 -> reg_addr=0x04, reg_we=1, reg_wdata=0x55; after reg_done one tx_send with 0x06.
REQ-036 Timeout (TIMEOUT=16): read 0x01, reg_done never -> reg_req high exactly 16 cycles, tx_data=0x15, err=1; later reg_done ignored.
REQ-037 Invalid: rx byte 0x40 -> no reg_req, tx_send with 0x15, err=1; next valid command processes normally.
REQ-038 Back-pressure/ordering: tx_full=1 for 20 cycles at RESPOND, two queued reads -> tx_send waits, rx_nxt not asserted meanwhile, responses in order, no consecutive rx_nxt.
REQ-039 Reset in ACCESS: rst pulsed while reg_req=1 -> reg_req=0 same cycle, busy=0, no tx_send afterwards.

Source files
------------

// File: rtl/sniffer_cmd_ctrl.sv
// sniffer_cmd_ctrl
//   Turns command bytes from a UART Rx FIFO into ULPI register accesses and
//   returns one response byte per command to the UART Tx side.
//   Command byte: bit7 = write, bit6 must be 0, bits5:0 = register address.
//   A write command is followed by one data byte. Responses: read data,
//   0x06 (write acknowledged) or 0x15 (invalid command / access timeout).
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   rx_data/rx_empty      : FWFT head of the Rx FIFO; rx_nxt pops it
//   tx_data/tx_send       : response byte and its write strobe; tx_full stalls
//   reg_addr/reg_wdata/
//   reg_we/reg_req        : register access request held until reg_done
//   reg_rdata/reg_done    : access completion pulse and read value
//   busy                  : FSM not idle
//   err                   : sticky error since reset
module sniffer_cmd_ctrl #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       rx_nxt,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_full,
  output logic [5:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_req,
  input  logic [7:0] reg_rdata,
  input  logic       reg_done,
  output logic       busy,
  output logic       err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  // Count value held in the last allowed ACCESS cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  typedef enum logic [1:0] {
    IDLE,
    GET_DATA,
    ACCESS,
    RESPOND
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    addr_q, addr_d;
  logic          we_q, we_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    resp_q, resp_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          popped_q, popped_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      resp_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      popped_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      resp_q   <= resp_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      popped_q <= popped_d;
    end
  end

  logic pop;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    resp_d   = resp_q;
    err_d    = err_q;
    cnt_d    = '0;
    popped_d = 1'b0;
    pop      = 1'b0;
    reg_req  = 1'b0;
    tx_send  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_empty) begin
          pop    = 1'b1;
          addr_d = rx_data[5:0];
          we_d   = rx_data[7];
          if (rx_data[6]) begin
            resp_d  = RESP_NAK;
            err_d   = 1'b1;
            state_d = RESPOND;
          end else if (rx_data[7]) begin
            state_d = GET_DATA;
          end else begin
            state_d = ACCESS;
          end
        end
      end

      GET_DATA: begin
        // rx_empty may still describe the byte just popped; skip that cycle.
        if (!popped_q && !rx_empty) begin
          pop     = 1'b1;
          wdata_d = rx_data;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        reg_req = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // Completion takes priority over a timeout in the same cycle.
        if (reg_done) begin
          resp_d  = we_q ? RESP_ACK : reg_rdata;
          state_d = RESPOND;
        end else if (cnt_q == CNT_LAST) begin
          resp_d  = RESP_NAK;
          err_d   = 1'b1;
          state_d = RESPOND;
        end
      end

      RESPOND: begin
        if (!tx_full) begin
          tx_send = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    popped_d = pop;
  end

  // Reset leaves the state at IDLE, where a non-empty FIFO would otherwise pop.
  assign rx_nxt    = pop && !rst;
  assign tx_data   = resp_q;
  assign reg_addr  = addr_q;
  assign reg_we    = we_q;
  assign reg_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_sniffer_cmd_ctrl.sv
// tb_sniffer_cmd_ctrl
//   Directed bench for sniffer_cmd_ctrl (TIMEOUT = 16). A transaction-level
//   model turns each issued command into expected register accesses and
//   response bytes; a negedge monitor compares the DUT against it, and the
//   main sequence adds literal expectations per scenario.
module tb_sniffer_cmd_ctrl;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'hEE;
  logic       rx_empty = 1'b1;
  logic       rx_nxt;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_full = 1'b0;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_req;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_done = 1'b0;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  sniffer_cmd_ctrl #(.TIMEOUT(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_empty  (rx_empty),
    .rx_nxt    (rx_nxt),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_full   (tx_full),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_req   (reg_req),
    .reg_rdata (reg_rdata),
    .reg_done  (reg_done),
    .busy      (busy),
    .err       (err)
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic        we;
    logic [7:0]  wdata;
    int unsigned len;
  } acc_t;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } resp_t;

  typedef struct packed {
    int unsigned delay;   // reg_done in this access cycle; 0 = never
    logic [7:0]  rdata;
  } plan_t;

  logic [7:0] rx_q[$];
  acc_t       exp_acc_q[$];
  resp_t      exp_resp_q[$];
  plan_t      plan_q[$];
  logic       model_err = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: what one command must produce, from the command-level rules.
  task automatic issue(input logic [7:0] cmd, input logic [7:0] dat,
                       input int unsigned delay, input logic [7:0] rdata);
    logic        ok;
    int unsigned len;
    rx_q.push_back(cmd);
    if (cmd[6]) begin
      model_err = 1'b1;
      exp_resp_q.push_back('{8'h15, 1'b1});
      return;
    end
    if (cmd[7]) rx_q.push_back(dat);
    plan_q.push_back('{delay, rdata});
    ok  = (delay != 0) && (delay <= T);
    len = ok ? delay : T;
    exp_acc_q.push_back('{cmd[5:0], cmd[7], dat, len});
    if (!ok) model_err = 1'b1;
    exp_resp_q.push_back('{ok ? (cmd[7] ? 8'h06 : rdata) : 8'h15, model_err});
  endtask

  // FIFO and ULPI responder, driven 1 time unit after each rising edge.
  logic        pop_seen = 1'b0;
  int unsigned req_cyc = 0;
  plan_t       cur = '0;
  int          stray_req = 0;
  int          stray_ack = 0;

  always @(posedge clk) begin
    #1;
    if (pop_seen && rx_q.size() > 0) void'(rx_q.pop_front());
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'hEE : rx_q[0];
    reg_done = 1'b0;
    if (reg_req) begin
      req_cyc++;
      if (req_cyc == 1) cur = (plan_q.size() > 0) ? plan_q.pop_front() : '0;
      reg_done  = (cur.delay != 0) && (req_cyc == cur.delay);
      reg_rdata = reg_done ? cur.rdata : ~cur.rdata;
    end else begin
      req_cyc   = 0;
      reg_rdata = 8'hC3;
      reg_done  = (stray_req != stray_ack);
    end
    stray_ack = stray_req;
  end

  // Monitor.
  logic        prev_req = 1'b0, prev_rx_nxt = 1'b0, prev_tx_send = 1'b0, prev_err = 1'b0;
  logic        in_cmd = 1'b0, await_data = 1'b0;
  logic [5:0]  s_addr = '0;
  logic        s_we = 1'b0;
  logic [7:0]  s_wdata = '0;
  int unsigned req_len = 0;
  acc_t        cur_exp = '0;
  resp_t       r;
  int          pop_count = 0, tx_count = 0, acc_count = 0;
  logic [7:0]  last_tx = '0;
  int unsigned last_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      pop_seen     = 1'b0;
      prev_req     = 1'b0;
      prev_rx_nxt  = 1'b0;
      prev_tx_send = 1'b0;
      prev_err     = 1'b0;
      in_cmd       = 1'b0;
      await_data   = 1'b0;
    end else begin
      pop_seen = rx_nxt;
      if (rx_nxt) begin
        pop_count++;
        chk("rx_nxt_back_to_back", prev_rx_nxt, 1'b0);
        chk("rx_nxt_when_empty", rx_empty, 1'b0);
        if (!in_cmd) begin
          in_cmd     = 1'b1;
          await_data = rx_data[7] & ~rx_data[6];
          chk("busy_at_cmd_pop", busy, 1'b0);
        end else begin
          chk("pop_only_for_data_byte", await_data, 1'b1);
          await_data = 1'b0;
        end
      end
      if (reg_req && !prev_req) begin
        acc_count++;
        chk("req_follows_pop", prev_rx_nxt, 1'b1);
        chk("access_expected", exp_acc_q.size() > 0, 1'b1);
        if (exp_acc_q.size() > 0) begin
          cur_exp = exp_acc_q.pop_front();
          chk("reg_addr", reg_addr, cur_exp.addr);
          chk("reg_we", reg_we, cur_exp.we);
          if (cur_exp.we) chk("reg_wdata", reg_wdata, cur_exp.wdata);
        end
        s_addr  = reg_addr;
        s_we    = reg_we;
        s_wdata = reg_wdata;
        req_len = 0;
      end
      if (reg_req) begin
        req_len++;
        chk("req_fields_stable", {reg_addr, reg_we, reg_wdata}, {s_addr, s_we, s_wdata});
        chk("busy_in_access", busy, 1'b1);
      end
      if (!reg_req && prev_req) begin
        chk("req_length", req_len, cur_exp.len);
        last_len = req_len;
        if (!tx_full) chk("tx_send_after_access", tx_send, 1'b1);
      end
      if (tx_full) chk("no_send_while_full", tx_send, 1'b0);
      if (tx_send) begin
        tx_count++;
        chk("response_expected", exp_resp_q.size() > 0, 1'b1);
        if (exp_resp_q.size() > 0) begin
          r = exp_resp_q.pop_front();
          chk("tx_data", tx_data, r.data);
          chk("err_at_send", err, r.err);
        end
        chk("busy_in_respond", busy, 1'b1);
        last_tx = tx_data;
        in_cmd  = 1'b0;
      end
      if (prev_tx_send) chk("idle_after_send", busy, 1'b0);
      if (prev_err) chk("err_sticky", err, 1'b1);
      prev_req     = reg_req;
      prev_rx_nxt  = rx_nxt;
      prev_tx_send = tx_send;
      prev_err     = err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_idle(input int unsigned maxc);
    int unsigned c = 0;
    while ((rx_q.size() != 0 || exp_resp_q.size() != 0 || busy) && c < maxc) begin
      tick();
      c++;
    end
    chk("idle_within_budget", c < maxc, 1'b1);
    tick();
  endtask

  task automatic clear_model();
    exp_acc_q.delete();
    exp_resp_q.delete();
    plan_q.delete();
    model_err = 1'b0;
  endtask

  initial begin
    int t0, a0, p0;
    repeat (3) tick();
    chk("rst_rx_nxt", rx_nxt, 1'b0);
    chk("rst_tx_send", tx_send, 1'b0);
    chk("rst_reg_req", reg_req, 1'b0);
    chk("rst_reg_we", reg_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_reg_addr", reg_addr, 6'h00);
    chk("rst_reg_wdata", reg_wdata, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    tick();

    // Read 0x0A, done after 5 cycles with 0x24.
    t0 = tx_count;
    issue(8'h0A, 8'h00, 5, 8'h24);
    wait_idle(100);
    chk("read_sends", tx_count - t0, 1);
    chk("read_tx", last_tx, 8'h24);
    chk("read_addr", s_addr, 6'h0A);
    chk("read_we", s_we, 1'b0);
    chk("read_len", last_len, 5);
    chk("read_err", err, 1'b0);

    // Write 0x84, 0x55.
    t0 = tx_count;
    issue(8'h84, 8'h55, 3, 8'h00);
    wait_idle(100);
    chk("write_sends", tx_count - t0, 1);
    chk("write_tx", last_tx, 8'h06);
    chk("write_addr", s_addr, 6'h04);
    chk("write_we", s_we, 1'b1);
    chk("write_wdata", s_wdata, 8'h55);
    chk("write_err", err, 1'b0);

    // Invalid command, then a normal read.
    a0 = acc_count;
    issue(8'h40, 8'h00, 0, 8'h00);
    wait_idle(100);
    chk("inv_no_access", acc_count - a0, 0);
    chk("inv_tx", last_tx, 8'h15);
    chk("inv_err", err, 1'b1);
    issue(8'h3F, 8'h00, 1, 8'hA5);
    wait_idle(100);
    chk("after_inv_tx", last_tx, 8'hA5);
    chk("after_inv_addr", s_addr, 6'h3F);
    chk("after_inv_len", last_len, 1);

    // Plain reset clears err.
    rst = 1'b1;
    clear_model();
    tick();
    chk("err_cleared", err, 1'b0);
    rst = 1'b0;
    tick();

    // Timeout, then a stray reg_done while idle.
    t0 = tx_count;
    a0 = acc_count;
    issue(8'h01, 8'h00, 0, 8'h00);
    wait_idle(100);
    chk("to_len", last_len, 16);
    chk("to_tx", last_tx, 8'h15);
    chk("to_err", err, 1'b1);
    stray_req++;
    repeat (6) tick();
    chk("stray_no_send", tx_count - t0, 1);
    chk("stray_no_access", acc_count - a0, 1);
    chk("stray_busy", busy, 1'b0);

    // Done in the last allowed cycle wins; one cycle later is too late.
    issue(8'h2B, 8'h00, 16, 8'h5A);
    wait_idle(100);
    chk("edge_len", last_len, 16);
    chk("edge_tx", last_tx, 8'h5A);
    issue(8'h2C, 8'h00, 17, 8'h99);
    wait_idle(100);
    chk("late_tx", last_tx, 8'h15);

    // Back-pressure with two queued reads.
    tx_full = 1'b1;
    p0 = pop_count;
    t0 = tx_count;
    issue(8'h11, 8'h00, 2, 8'h77);
    issue(8'h12, 8'h00, 4, 8'h88);
    repeat (25) tick();
    chk("bp_one_pop", pop_count - p0, 1);
    chk("bp_no_send", tx_count - t0, 0);
    chk("bp_busy", busy, 1'b1);
    tx_full = 1'b0;
    wait_idle(100);
    chk("bp_sends", tx_count - t0, 2);
    chk("bp_pops", pop_count - p0, 2);
    chk("bp_last_tx", last_tx, 8'h88);

    // Reset while the access is outstanding.
    issue(8'h22, 8'h00, 0, 8'h00);
    begin
      int unsigned c = 0;
      while (!reg_req && c < 50) begin
        tick();
        c++;
      end
      chk("reached_access", reg_req, 1'b1);
    end
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("rst_drops_req", reg_req, 1'b0);
    chk("rst_busy_now", busy, 1'b0);
    chk("rst_tx_send_now", tx_send, 1'b0);
    clear_model();
    tick();
    rst = 1'b0;
    t0 = tx_count;
    repeat (30) tick();
    chk("abort_no_send", tx_count - t0, 0);
    chk("abort_err", err, 1'b0);
    chk("abort_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
